// File: rtl/uart_proto_pkg.sv
// Shared UART protocol definitions: framing bytes, destination and command codes,
// and the TX arbiter state/beat types.
package uart_proto_pkg;

    localparam logic [7:0] START_OF_MSG = 8'hAA;
    localparam logic [7:0] END_OF_MSG   = 8'hFF;

    localparam logic [7:0] PC_TO_FPGA   = 8'h01;
    localparam logic [7:0] FPGA_TO_PC   = 8'h10;

    localparam logic [7:0] CMD_READ     = 8'h11;
    localparam logic [7:0] CMD_WRITE    = 8'h21;
    localparam logic [7:0] CMD_STATUS   = 8'h31;

    localparam int GRANT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN
    } arb_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } axis_beat_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin pick: first set request at or above ptr, modulo N.
// Expects ptr < N.
module rr_select #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*N-1:0] rot;
    int             pos;

    // Rotating the doubled vector puts the request at ptr on bit 0.
    assign rot = {req, req} >> ptr;

    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = 0;
        for (int k = 0; k < N; k++) begin
            if (!any && rot[k]) begin
                any = 1'b1;
                pos = int'(ptr) + k;
                if (pos >= N) pos = pos - N;
                idx = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-level round-robin arbiter onto the single UART TX byte stream, with a
// watchdog that reclaims the channel from a source that stalls mid-frame.
module uart_tx_arbiter
    import uart_proto_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [8*N_REQ-1:0] s_axis_tdata,
    input  logic [N_REQ-1:0]   s_axis_tvalid,
    input  logic [N_REQ-1:0]   s_axis_tlast,
    output logic [N_REQ-1:0]   s_axis_tready,
    output logic [7:0]         uart_tx_axis_tdata,
    output logic               uart_tx_axis_tvalid,
    input  logic               uart_tx_axis_tready,
    output logic [2:0]         grant_id,
    output logic               busy,
    output logic               timeout_err
);

    localparam int              WD_W   = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    arb_state_e           state_q, state_d;
    logic [GRANT_W-1:0]   grant_q, grant_d;
    logic [GRANT_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GRANT_W-1:0]   pick_idx;
    logic                 pick_any;
    logic                 busy_q, busy_d;
    logic                 tmo_q, tmo_d;
    logic                 out_vld_q, out_vld_d;
    axis_beat_t           out_q, out_d;
    logic [WD_W-1:0]      wd_q, wd_d;

    logic [N_REQ-1:0][7:0] src_bytes;
    logic                  src_vld, src_last;
    logic [7:0]            src_data;
    logic                  out_ready, src_hs, out_hs, stall;

    rr_select #(.N(N_REQ), .IDX_W(GRANT_W)) u_rr_select (
        .req (s_axis_tvalid),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign src_bytes = s_axis_tdata;

    always_comb begin
        src_vld  = 1'b0;
        src_last = 1'b0;
        src_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == GRANT_W'(i)) begin
                src_vld  = s_axis_tvalid[i];
                src_last = s_axis_tlast[i];
                src_data = src_bytes[i];
            end
        end
    end

    // Output register is a one-deep skid: refill in the same cycle it drains.
    assign out_ready = !out_vld_q || uart_tx_axis_tready;
    assign out_hs    = out_vld_q && uart_tx_axis_tready;
    assign src_hs    = (state_q == XFER) && src_vld && out_ready;
    assign stall     = (state_q == XFER) && !src_vld && !out_vld_q;

    for (genvar g = 0; g < N_REQ; g++) begin : g_rdy
        assign s_axis_tready[g] = (state_q == XFER) && (grant_q == GRANT_W'(g)) && out_ready;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        busy_d    = busy_q;
        tmo_d     = 1'b0;
        out_vld_d = out_vld_q;
        out_d     = out_q;
        wd_d      = wd_q;

        if (out_hs) out_vld_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                wd_d = '0;
                if (pick_any) begin
                    grant_d  = pick_idx;
                    rr_ptr_d = (pick_idx == GRANT_W'(N_REQ - 1)) ? '0 : pick_idx + 3'd1;
                    busy_d   = 1'b1;
                    state_d  = XFER;
                end
            end
            XFER: begin
                if (src_hs) begin
                    out_d.data = src_data;
                    out_d.last = src_last;
                    out_vld_d  = 1'b1;
                    wd_d       = '0;
                    if (src_last) state_d = DRAIN;
                end else if (stall) begin
                    // Only source starvation counts; a full output register means downstream backpressure.
                    if (wd_q == WD_MAX) begin
                        tmo_d   = 1'b1;
                        busy_d  = 1'b0;
                        wd_d    = '0;
                        state_d = IDLE;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_hs && out_q.last) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            busy_q    <= 1'b0;
            tmo_q     <= 1'b0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            busy_q    <= busy_d;
            tmo_q     <= tmo_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
            wd_q      <= wd_d;
        end
    end

    assign uart_tx_axis_tdata  = out_q.data;
    assign uart_tx_axis_tvalid = out_vld_q;
    assign grant_id            = grant_q;
    assign busy                = busy_q;
    assign timeout_err         = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: grant table, then frame sequences checked against
// an expected-byte scoreboard filled in arbitration order.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    import uart_proto_pkg::*;

    localparam int N   = 2;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [8*N-1:0] s_tdata;
    logic [N-1:0]   s_tvalid, s_tlast, s_tready, pres_vld;
    logic [7:0]     u_tdata;
    logic           u_tvalid, u_tready;
    logic [2:0]     grant_id;
    logic           busy, timeout_err;

    always #5 clk = ~clk;

    // Source tvalid drops in the same instant reset is asserted.
    assign s_tvalid = rst_n ? pres_vld : '0;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .s_axis_tdata        (s_tdata),
        .s_axis_tvalid       (s_tvalid),
        .s_axis_tlast        (s_tlast),
        .s_axis_tready       (s_tready),
        .uart_tx_axis_tdata  (u_tdata),
        .uart_tx_axis_tvalid (u_tvalid),
        .uart_tx_axis_tready (u_tready),
        .grant_id            (grant_id),
        .busy                (busy),
        .timeout_err         (timeout_err)
    );

    typedef struct { logic [7:0] d; logic last; } beat_t;
    typedef struct { logic [7:0] d; int src; } exp_t;
    typedef struct { logic [N-1:0] req; int grant; } vec_t;

    beat_t src_q [N][$];
    exp_t  exp_q[$];
    int    out_cyc_q[$];
    int    cyc = 0, checks = 0, errors = 0;
    int    tmo_cnt = 0, tmo_cyc = -1, busy_fall_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic frame(input int s, input logic [63:0] b, input int n, input bit lastf);
        logic [7:0] d;
        for (int k = 0; k < n; k++) begin
            d = b[8*(n-1-k) +: 8];
            src_q[s].push_back('{d: d, last: lastf && (k == n - 1)});
            exp_q.push_back('{d: d, src: s});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        out_cyc_q.delete();
        tmo_cnt = 0; tmo_cyc = -1; busy_fall_cyc = -1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_busy(input int maxc);
        int n = 0;
        while (!busy && n < maxc) begin @(negedge clk); n++; end
        chk("busy_seen", busy, 1);
    endtask

    task automatic wait_done(input string nm, input int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < maxc) begin @(negedge clk); n++; end
        chk({nm, "_pending"}, exp_q.size(), 0);
        chk({nm, "_busy"}, busy, 0);
    endtask

    task automatic wait_out(input int cnt, input int maxc);
        int n = 0;
        while (out_cyc_q.size() < cnt && n < maxc) begin @(negedge clk); n++; end
        chk("out_count_reached", out_cyc_q.size() >= cnt, 1);
    endtask

    // Source feeder: presents each queue head, pops it after a handshake.
    initial begin
        logic [N-1:0] hs;
        pres_vld = '0; s_tlast = '0; s_tdata = '0;
        forever begin
            @(negedge clk);
            hs = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    pres_vld[i]       = 1'b1;
                    s_tdata[8*i +: 8] = src_q[i][0].d;
                    s_tlast[i]        = src_q[i][0].last;
                end else begin
                    pres_vld[i] = 1'b0;
                    s_tlast[i]  = 1'b0;
                end
            end
        end
    end

    // Output monitor: scoreboard pop, AXI hold rule, timeout and busy events.
    initial begin
        exp_t       e;
        logic       hold_pend = 1'b0, prev_busy = 1'b0;
        logic [7:0] hold_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pend = 1'b0;
                prev_busy = 1'b0;
            end else begin
                if (hold_pend) begin
                    chk("axis_hold_valid", u_tvalid, 1);
                    chk("axis_hold_data", u_tdata, hold_data);
                end
                if (u_tvalid && u_tready) begin
                    out_cyc_q.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_byte: got %0h expected no output (cycle %0d)", u_tdata, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", u_tdata, e.d);
                        chk("out_src", grant_id, e.src);
                    end
                end
                hold_pend = u_tvalid && !u_tready;
                hold_data = u_tdata;
                if (timeout_err) begin tmo_cnt++; tmo_cyc = cyc; end
                if (prev_busy && !busy) busy_fall_cyc = cyc;
                prev_busy = busy;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        vec_t tbl [7];
        int   k, h;
        u_tready = 1'b1;

        // Grant table from reset: rr_ptr walks 0->1->0->1->1->0->0.
        tbl[0] = '{req: 2'b01, grant: 0};
        tbl[1] = '{req: 2'b11, grant: 1};
        tbl[2] = '{req: 2'b11, grant: 0};
        tbl[3] = '{req: 2'b01, grant: 0};
        tbl[4] = '{req: 2'b10, grant: 1};
        tbl[5] = '{req: 2'b10, grant: 1};
        tbl[6] = '{req: 2'b11, grant: 0};

        repeat (2) @(negedge clk);
        chk("rst_tvalid", u_tvalid, 0);
        chk("rst_tdata", u_tdata, 0);
        chk("rst_tready", s_tready, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (tbl[t].req[i]) src_q[i].push_back('{d: 8'h40 + 8'(i), last: 1'b1});
            wait_busy(10);
            chk("tbl_grant", grant_id, tbl[t].grant);
            for (int i = 0; i < N; i++) if (i != tbl[t].grant) src_q[i].delete();
            exp_q.push_back('{d: 8'h40 + 8'(tbl[t].grant), src: tbl[t].grant});
            wait_done("tbl", 20);
        end

        // Single source: output on 5 consecutive cycles, 2 after first tvalid.
        do_reset();
        @(negedge clk);
        k = cyc;
        frame(0, {START_OF_MSG, PC_TO_FPGA, FPGA_TO_PC, 8'h11, END_OF_MSG}, 5, 1'b1);
        wait_done("single", 40);
        chk("single_nbytes", out_cyc_q.size(), 5);
        for (int j = 0; j < 5 && j < out_cyc_q.size(); j++) chk("single_byte_cycle", out_cyc_q[j], k + 3 + j);
        chk("single_busy_fall", busy_fall_cyc, k + 8);

        // Contention: whole frame from 0, idle gap, whole frame from 1.
        do_reset();
        frame(0, {START_OF_MSG, FPGA_TO_PC, PC_TO_FPGA, 8'h11, END_OF_MSG}, 5, 1'b1);
        frame(1, {START_OF_MSG, FPGA_TO_PC, 8'h11, 8'h21, END_OF_MSG}, 5, 1'b1);
        wait_done("contend", 60);
        chk("contend_nbytes", out_cyc_q.size(), 10);
        if (out_cyc_q.size() == 10) begin
            chk("contend_frame0_back2back", out_cyc_q[4] - out_cyc_q[0], 4);
            chk("contend_gap_ge3", (out_cyc_q[5] - out_cyc_q[4]) >= 3, 1);
        end

        // Fairness: 3 frames each, granted 0,1,0,1,0,1.
        do_reset();
        for (int f = 0; f < 3; f++) begin
            frame(0, {8'h60 + 8'(f), END_OF_MSG}, 2, 1'b1);
            frame(1, {8'h70 + 8'(f), END_OF_MSG}, 2, 1'b1);
        end
        wait_done("fair", 100);
        chk("fair_nbytes", out_cyc_q.size(), 12);

        // Backpressure: UART stalls 50 cycles mid-frame.
        do_reset();
        frame(0, 64'h8182_8384_8586_8788, 8, 1'b1);
        wait_out(3, 20);
        @(posedge clk); #1 u_tready = 1'b0;
        repeat (50) @(posedge clk);
        #1 u_tready = 1'b1;
        wait_done("bp", 40);
        chk("bp_nbytes", out_cyc_q.size(), 8);
        chk("bp_no_timeout", tmo_cnt, 0);

        // Starvation: source 1 stops after AA 10; abort, then source 0 runs.
        do_reset();
        frame(1, {START_OF_MSG, FPGA_TO_PC}, 2, 1'b0);
        wait_out(2, 20);
        h = out_cyc_q[1];
        frame(0, {START_OF_MSG, PC_TO_FPGA, END_OF_MSG}, 3, 1'b1);
        wait_done("starve", 80);
        chk("starve_pulses", tmo_cnt, 1);
        chk("starve_pulse_cycle", tmo_cyc, h + TMO + 1);
        chk("starve_nbytes", out_cyc_q.size(), 5);

        // Reset mid-frame: partial frame dropped, rr_ptr back to 0.
        do_reset();
        frame(0, 64'h0000_9192_9394_9596, 6, 1'b1);
        wait_out(2, 20);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        out_cyc_q.delete();
        #1;
        chk("midrst_tvalid", u_tvalid, 0);
        chk("midrst_tdata", u_tdata, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tready", s_tready, 0);
        chk("midrst_grant", grant_id, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame(0, {START_OF_MSG, PC_TO_FPGA, END_OF_MSG}, 3, 1'b1);
        frame(1, {START_OF_MSG, FPGA_TO_PC, END_OF_MSG}, 3, 1'b1);
        wait_done("midrst", 40);
        chk("midrst_nbytes", out_cyc_q.size(), 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Frame-level round-robin arbiter that shares the single UART TX AXI-stream byte channel among `N_REQ` frame sources: the command parser's reply path, a status reporter, a debug dump. It sits between those sources and the UART transmitter. It grants one source for a whole frame (first byte through `tlast`), so frames never interleave on the wire. A watchdog reclaims the channel if a granted source stalls mid-frame.

## Interface
- `N_REQ`, 2: number of requesting sources, 2..8.
- `TIMEOUT`, 1_000_000: source-starvation cycles tolerated mid-frame before abort (10 ms at 100 MHz); ≥ 2.
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_axis_tdata`  in  8*N_REQ  source bytes; source i on bits [8i+7:8i].
- `s_axis_tvalid`  in  N_REQ  per-source byte valid.
- `s_axis_tlast`  in  N_REQ  per-source last byte of frame.
- `s_axis_tready`  out  N_REQ  per-source ready.
- `uart_tx_axis_tdata`  out  8  byte to UART TX.
- `uart_tx_axis_tvalid`  out  1  byte valid.
- `uart_tx_axis_tready`  in  1  UART TX ready.
- `grant_id`  out  3  index of the currently granted source; valid while `busy`.
- `busy`  out  1  high while a frame is owned (ARB excluded).
- `timeout_err`  out  1  one-cycle pulse when a frame is aborted.

## Operation
- FSM states: IDLE, XFER, DRAIN.
- IDLE:
  - If any `s_axis_tvalid` is high, pick the first requester at or after `rr_ptr`, searching upward modulo `N_REQ`.
  - Register it in `grant_id`, set `busy`, and go to XFER.
  - The next cycle `rr_ptr` loads `grant_id+1` (wraps `N_REQ-1`→0).
- XFER:
  - `s_axis_tready[grant_id] = !uart_tx_axis_tvalid || uart_tx_axis_tready`. All other readies are 0.
  - A source handshake loads the output register: tdata and tvalid, plus an internal `last_q` from tlast.
  - A source handshake with tlast goes to DRAIN.
- DRAIN: the granted ready is 0. When the output handshake completes with `last_q`, go to IDLE and clear `busy`.
- Watchdog:
  - The counter increments in XFER only while `s_axis_tvalid[grant_id]`=0 and the output register is empty.
  - The counter clears on every source handshake and in IDLE. Downstream backpressure never counts.
  - When the count reaches `TIMEOUT-1`: pulse `timeout_err`, go to IDLE, clear `busy`. `rr_ptr` has already advanced. The truncated frame is not padded; the receiver rejects it by checksum/tail.
- Frames are opaque to this block: no inspection of 0xAA/0xFF framing, no checksum recomputation.
- A single-byte frame (tlast on the first byte) is legal and goes straight to DRAIN.

## Timing
- Reset values:
  - `uart_tx_axis_tvalid`=0, `uart_tx_axis_tdata`=0.
  - `s_axis_tready`=0, `grant_id`=0, `busy`=0, `timeout_err`=0.
  - `rr_ptr`=0, FSM=IDLE, watchdog=0.
- Grant latency: 1 cycle. tvalid seen in IDLE at cycle t → XFER and ready at t+1.
- Data latency: the byte accepted from the source at cycle t is on `uart_tx_axis_*` at t+1.
- Throughput: one byte per cycle within a frame when the UART is always ready.
- Inter-frame gap: at least one IDLE cycle between the last output handshake and the next grant.
- The output is AXI-stream compliant: tdata is stable and tvalid never drops while tvalid && !tready.
- Simultaneous requests in IDLE are resolved by `rr_ptr` only, never by fixed index.
- A new request arriving during XFER/DRAIN is not seen until IDLE.
- `rst_n` asserted mid-frame: all outputs take reset values asynchronously, and the partial frame is dropped.
- The watchdog counter width is `$clog2(TIMEOUT)`. It saturates and never wraps.

## Structure
- Shared package `uart_proto_pkg`:
  - Framing constants START_OF_MSG 8'hAA and END_OF_MSG 8'hFF.
  - Destination codes PC_TO_FPGA 8'h01 and FPGA_TO_PC 8'h10.
  - Command codes and the arbiter state enum.
- One sub-module, `rr_select`: combinational round-robin priority pick (`req[N_REQ]`, `ptr` → `idx`, `any`). It is reusable by other shared-resource arbiters.

## Test plan
- Single source: source 0 sends AA 01 10 11 FF with the UART always ready. Output shows AA 01 10 11 FF on 5 consecutive cycles starting 2 cycles after the first tvalid. `busy` drops after the FF handshake.
- Contention: both sources hold tvalid from cycle 0 with frames AA 10 01 11 FF and AA 10 11 21 FF. Source 0's frame completes whole, then source 1's. There is no interleaving and at least 1 idle cycle between frames.
- Fairness: both sources request continuously for 6 frames. Grants alternate 0,1,0,1,0,1.
- Backpressure: the UART drops ready for 50 cycles mid-frame. tdata is held stable, no byte is lost or duplicated, and `timeout_err` stays 0.
- Starvation: with `TIMEOUT`=16, source 1 sends AA 10 then deasserts tvalid. `timeout_err` pulses exactly once, 16 cycles after the last handshake. Source 0's pending frame is granted next.
- Reset mid-frame: `rst_n` goes low during byte 3. tvalid drops in the same cycle. After release, the next frame starts from `rr_ptr`=0.
